gpr_snapshot_loader: RTL
========================

// Module: gpr_snapshot_loader
// PURPOSE
//  Load direction of the GPR debug path: the simulator streams a 32-entry GPR
//  snapshot into the core, one word per handshake, restoring architectural state.
//  Owns the GPR array, serves the core's 2R1W ports and exports the flat array
//  for the display/difftest side.
//  Sits between the DPI loader harness and the decode/writeback stages.
// PARAMETERS
//  XLEN   32  register width in bits
//  NREGS  32  register count; index width is $clog2(NREGS)
// PORTS
//  clock      in   1            single clock, all state on rising edge
//  reset      in   1            asynchronous, active-low; clears all state
//  ld_start   in   1            request snapshot load (sampled in IDLE only)
//  ld_abort   in   1            abandon load in progress
//  ld_valid   in   1            ld_data holds next snapshot word
//  ld_data    in   XLEN         snapshot word for register ld_idx
//  ld_ready   out  1            loader accepts a word this cycle
//  ld_idx     out  5            index of register the next word is written to
//  ld_busy    out  1            load in progress; core must stall
//  ld_done    out  1            one-cycle pulse: all NREGS words accepted
//  rs1_addr   in   5            read port 1 address
//  rs1_data   out  XLEN         read port 1 data, combinational
//  rs2_addr   in   5            read port 2 address
//  rs2_data   out  XLEN         read port 2 data, combinational
//  wen        in   1            core writeback enable
//  waddr      in   5            core writeback address
//  wdata      in   XLEN         core writeback data
//  regs_flat  out  XLEN*NREGS   reg i at [i*XLEN +: XLEN], for display export
// BEHAVIOUR
//  Reset (reset==0, async):
//   - all regs 0, state IDLE, ld_idx 0
//   - ld_ready/ld_busy/ld_done 0
//  FSM states IDLE, LOAD, DONE:
//   - IDLE -> LOAD on ld_start; ld_idx<=0
//   - LOAD: ld_ready=1, ld_busy=1
//     - handshake (ld_valid&&ld_ready) writes regs[ld_idx]<=ld_data, ld_idx++
//     - handshake at ld_idx==NREGS-1 -> DONE, ld_idx wraps to 0
//   - LOAD -> IDLE on ld_abort; abort wins over a same-cycle handshake
//     - that word is dropped; words already written stay; no ld_done
//   - DONE: ld_done=1, ld_busy=1, ld_ready=0; next cycle -> IDLE unconditionally
//  Ignored inputs:
//   - ld_start outside IDLE; ld_valid outside LOAD
//   - ld_abort outside LOAD
//  x0:
//   - word for index 0 is accepted (handshake, idx advance) but discarded
//   - core writes to x0 ignored; reads of x0 return 0
//  Core write port:
//   - honoured only in IDLE; dropped while ld_busy
//   - the core guarantees wen==0 while stalled
//  Reads:
//   - combinational from array in every state, no bypass
//   - write at edge N is visible after edge N
//   - regs_flat likewise reflects the array after each edge
//  Latency: full load = NREGS accepted handshakes + 1 DONE cycle.
//   - ld_valid held high: ld_start at cycle 0, ld_done at cycle 33
//  Reset mid-load: array cleared, FSM IDLE; a new ld_start is required.
// STRUCTURE
//  Package gpr_pkg:
//   - XLEN/NREGS/REG_IDX_W localparams
//   - ld_state_e enum {IDLE,LOAD,DONE}
//  Sub-module gpr_array:
//   - storage, 2 read ports, 1 write port, x0 hardwiring
//  Top: FSM + index counter muxing the array's single write port
//   - LOAD selects the loader; IDLE selects the core
// TESTING
//  1. Release reset, start, stream 0x1000+i for i=0..31 with ld_valid=1
//     -> ld_done at cycle 33; regs[i]==0x1000+i for i>=1; x0==0
//  2. ld_valid toggled 1/0 each cycle during load
//     -> ld_idx advances only on handshake; ld_done after 32 accepted words
//  3. Abort after 10 words, with a same-cycle valid word
//     -> regs 1..9 loaded, reg 10 unchanged, no ld_done, IDLE next cycle
//  4. wen=1 waddr=5 wdata=0xDEAD in LOAD -> reg5 unchanged;
//     same write in IDLE -> rs1_addr=5 reads 0xDEAD next cycle
//  5. Drop reset mid-load at ld_idx=20 -> all regs 0, ld_busy=0 immediately
//  6. ld_start asserted during LOAD/DONE -> ignored; one ld_done pulse only

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared definitions for the GPR snapshot loader.
//   XLEN       register width in bits
//   NREGS      architectural register count
//   REG_IDX_W  register index width
//   ld_state_e loader FSM encoding (IDLE, LOAD, DONE)
package gpr_pkg;
  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = $clog2(NREGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;
endpackage

// File: rtl/gpr_array.sv
// GPR storage: NREGS x XLEN registers, two combinational read ports, one
// write port, with x0 hardwired to zero. Also exports the whole array flat.
// Ports:
//   clock, reset          rising-edge clock, async active-low clear
//   i_we/i_waddr/i_wdata  single write port (writes to x0 are dropped)
//   i_rs1_addr/o_rs1_data read port 1 (combinational, no bypass)
//   i_rs2_addr/o_rs2_data read port 2 (combinational, no bypass)
//   o_flat                reg i at [i*XLEN +: XLEN]
module gpr_array
  import gpr_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [REG_IDX_W-1:0]  i_waddr,
  input  logic [XLEN-1:0]       i_wdata,
  input  logic [REG_IDX_W-1:0]  i_rs1_addr,
  output logic [XLEN-1:0]       o_rs1_data,
  input  logic [REG_IDX_W-1:0]  i_rs2_addr,
  output logic [XLEN-1:0]       o_rs2_data,
  output logic [XLEN*NREGS-1:0] o_flat
);

  logic [XLEN-1:0] r_mem [NREGS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rs1_data = (i_rs1_addr == '0) ? '0 : r_mem[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == '0) ? '0 : r_mem[i_rs2_addr];

  // Entry 0 is never written, so it always exports zero.
  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign o_flat[g*XLEN +: XLEN] = r_mem[g];
  end

endmodule

// File: rtl/gpr_snapshot_loader.sv
// Load side of the GPR debug path: restores a 32-entry snapshot streamed one
// word per handshake, and otherwise serves the core's 2R1W register ports.
// Ports:
//   clock, reset                 rising-edge clock, async active-low clear
//   ld_start/ld_abort            begin (IDLE only) / abandon (LOAD only) a load
//   ld_valid/ld_data/ld_ready    snapshot word stream into register ld_idx
//   ld_idx                       register the next accepted word goes to
//   ld_busy                      load in progress, core must stall
//   ld_done                      one-cycle pulse after the last word
//   rs1_*/rs2_*                  combinational read ports
//   wen/waddr/wdata              core writeback, honoured only in IDLE
//   regs_flat                    whole array, reg i at [i*XLEN +: XLEN]
//   dbg_state                    current loader FSM state
//
// Handshake: a word transfers on a rising edge where ld_valid && ld_ready.
// ld_ready is high for the whole LOAD state and does not depend on ld_valid;
// a same-cycle ld_abort suppresses the transfer and the word is lost.
module gpr_snapshot_loader
  import gpr_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ld_start,
  input  logic                  ld_abort,
  input  logic                  ld_valid,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  ld_ready,
  output logic [REG_IDX_W-1:0]  ld_idx,
  output logic                  ld_busy,
  output logic                  ld_done,
  input  logic [REG_IDX_W-1:0]  rs1_addr,
  output logic [XLEN-1:0]       rs1_data,
  input  logic [REG_IDX_W-1:0]  rs2_addr,
  output logic [XLEN-1:0]       rs2_data,
  input  logic                  wen,
  input  logic [REG_IDX_W-1:0]  waddr,
  input  logic [XLEN-1:0]       wdata,
  output logic [XLEN*NREGS-1:0] regs_flat,
  output ld_state_e             dbg_state
);

  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NREGS - 1);

  ld_state_e            r_state;
  ld_state_e            w_next_state;
  logic [REG_IDX_W-1:0] r_idx;
  logic                 w_hs;
  logic                 w_we;
  logic [REG_IDX_W-1:0] w_waddr;
  logic [XLEN-1:0]      w_wdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    ld_ready     = 1'b0;
    ld_busy      = 1'b0;
    ld_done      = 1'b0;
    w_hs         = 1'b0;
    case (r_state)
      IDLE: begin
        if (ld_start) w_next_state = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
        if (ld_abort) begin
          w_next_state = IDLE;
        end else if (ld_valid) begin
          w_hs = 1'b1;
          if (r_idx == LAST_IDX) w_next_state = DONE;
        end
      end
      DONE: begin
        ld_done      = 1'b1;
        ld_busy      = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Index restarts on every accepted start; wraps to 0 on the last word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx <= '0;
    end else if ((r_state == IDLE) && ld_start) begin
      r_idx <= '0;
    end else if (w_hs) begin
      r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  // The array's single write port belongs to the loader in LOAD and to the
  // core in IDLE; nothing writes during DONE.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = waddr;
    w_wdata = wdata;
    if (r_state == LOAD) begin
      w_we    = w_hs;
      w_waddr = r_idx;
      w_wdata = ld_data;
    end else if (r_state == IDLE) begin
      w_we    = wen;
    end
  end

  gpr_array u_array (
    .clock      (clock),
    .reset      (reset),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (w_wdata),
    .i_rs1_addr (rs1_addr),
    .o_rs1_data (rs1_data),
    .i_rs2_addr (rs2_addr),
    .o_rs2_data (rs2_data),
    .o_flat     (regs_flat)
  );

  assign ld_idx    = r_idx;
  assign dbg_state = r_state;

endmodule
